arbitro_rr_4a1: RTL and testbench

//  Round-robin scheduler that drains four source FIFOs into one shared downstream FIFO.
//  It is the converse of the 1-to-4 word distributor.

---
 rtl/arbitro_pkg.sv | 19 +
 rtl/arbitro_rr_picker.sv | 23 ++
 rtl/arbitro_rr_4a1.sv | 130 +++++++++++++
 tb/tb_arbitro_rr_4a1.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_pkg.sv
// Shared constants, state encoding and helpers for the 4-to-1 round-robin FIFO drain.
package arbitro_pkg;

    localparam int WORD_SIZE_DEF = 12;
    localparam int FIFO_UNITS    = 4;
    localparam int BURST_DEF     = 4;
    localparam int BURST_CNT_W   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    // Source index that lies 'step' positions after 'base', wrapping modulo 4.
    function automatic logic [1:0] rr_offset(input logic [1:0] base, input int step);
        return base + 2'(step);
    endfunction

endpackage

// File: rtl/arbitro_rr_picker.sv
// Combinational round-robin pick: first requester after 'last', with 'last' itself searched last.
module rr_picker
    import arbitro_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] idx,
    output logic       any
);

    // Walk from farthest to nearest so the nearest requester is the one that sticks.
    always_comb begin
        idx = last;
        any = 1'b0;
        for (int k = FIFO_UNITS; k >= 1; k--) begin
            if (req[rr_offset(last, k)]) begin
                idx = rr_offset(last, k);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_rr_4a1.sv
// Round-robin scheduler draining four source FIFOs into one downstream FIFO, in bursts of up
// to BURST words per grant, with a two-stage registered path from pop to push.
module arbitro_rr_4a1
    import arbitro_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int BURST     = BURST_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             fifo_empty,
    input  logic [4*WORD_SIZE-1:0] data_in,
    input  logic                   out_almost_full,
    output logic [3:0]             pop,
    output logic [WORD_SIZE-1:0]   data_out,
    output logic                   push,
    output logic [1:0]             grant_id,
    output logic                   busy
);

    // Handshake: pop[g] is a combinational read strobe, only ever raised while source g is
    // non-empty and downstream is not almost full; the read word appears on data_in one cycle
    // later. push/data_out form a registered write strobe with no ready: downstream must keep
    // at least two free entries when it raises out_almost_full.

    state_t                 state_q, state_d;
    logic [1:0]             grant_d;
    logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [1:0]             last_grant_q, last_grant_d;

    logic [3:0] req;
    logic [1:0] pick_last;
    logic [1:0] pick_idx;
    logic       pick_any;
    logic       cur_empty;
    logic       burst_last;

    logic                 pop_d;
    logic [1:0]           g_d;
    logic [WORD_SIZE-1:0] src_word [FIFO_UNITS];

    assign req        = ~fifo_empty;
    assign cur_empty  = fifo_empty[grant_id];
    assign burst_last = (burst_cnt_q == BURST_CNT_W'(BURST - 1));
    assign busy       = (state_q == SERVE);

    // While serving, the next pick starts after the current grant, which becomes last_grant
    // on the same edge the rotation happens.
    assign pick_last = (state_q == SERVE) ? grant_id : last_grant_q;

    rr_picker u_picker (
        .req  (req),
        .last (pick_last),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_id;
        burst_cnt_d  = burst_cnt_q;
        last_grant_d = last_grant_q;
        pop          = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d     = SERVE;
                    grant_d     = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            SERVE: begin
                // A stall freezes everything, including rotation away from an emptied source.
                if (!out_almost_full) begin
                    if (!cur_empty) begin
                        pop[grant_id] = 1'b1;
                    end
                    if (cur_empty || burst_last) begin
                        last_grant_d = grant_id;
                        burst_cnt_d  = '0;
                        if (pick_any) begin
                            grant_d = pick_idx;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        burst_cnt_d = burst_cnt_q + BURST_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_id     <= 2'd0;
            burst_cnt_q  <= '0;
            last_grant_q <= 2'd3;
        end else begin
            state_q      <= state_d;
            grant_id     <= grant_d;
            burst_cnt_q  <= burst_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    for (genvar i = 0; i < FIFO_UNITS; i++) begin : g_src
        assign src_word[i] = data_in[i*WORD_SIZE +: WORD_SIZE];
    end

    // Stage 1 remembers which source was read; stage 2 captures that source's word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop_d    <= 1'b0;
            g_d      <= 2'd0;
            push     <= 1'b0;
            data_out <= '0;
        end else begin
            pop_d    <= |pop;
            g_d      <= grant_id;
            push     <= pop_d;
            data_out <= src_word[g_d];
        end
    end

endmodule

// File: tb/tb_arbitro_rr_4a1.sv
// Directed bench for arbitro_rr_4a1: behavioural source FIFOs plus a push scoreboard.
module tb_arbitro_rr_4a1;

    localparam int W = 12;

    logic           clk = 1'b0;
    logic           reset;
    logic [3:0]     fifo_empty;
    logic [4*W-1:0] data_in;
    logic           out_almost_full;
    logic [3:0]     pop;
    logic [W-1:0]   data_out;
    logic           push;
    logic [1:0]     grant_id;
    logic           busy;

    arbitro_rr_4a1 #(.WORD_SIZE(W), .BURST(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .fifo_empty      (fifo_empty),
        .data_in         (data_in),
        .out_almost_full (out_almost_full),
        .pop             (pop),
        .data_out        (data_out),
        .push            (push),
        .grant_id        (grant_id),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem [4][64];
    int           wr [4];
    int           rd [4];

    logic [W-1:0] exp_q [$];
    int           exp_cyc_q [$];
    int           pop_log [$];
    int           pop_cyc_log [$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_push   = 0;
    int push_before;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int src, input int n);
        for (int k = 0; k < n; k++) begin
            mem[src][wr[src]] = W'($urandom_range(1, 4095));
            wr[src]++;
        end
        fifo_empty[src] = (rd[src] == wr[src]);
    endtask

    // One clock: observe at the falling edge, then update the source model just after the rise.
    task automatic step();
        int           src;
        logic [W-1:0] w;
        int           c;
        src = -1;
        @(negedge clk);
        if (push) begin
            n_push++;
            if (exp_q.size() == 0) begin
                check("push_unexpected", 32'(push), 32'd0);
            end else begin
                w = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                check("push_data", 32'(data_out), 32'(w));
                check("push_latency", cyc, c);
            end
        end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
            check("push_missing", 32'(push), 32'd1);
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
        end
        if (pop != 4'd0) begin
            check("pop_onehot", 32'($onehot(pop)), 32'd1);
            for (int i = 0; i < 4; i++) if (pop[i]) src = i;
            check("pop_not_empty", 32'(fifo_empty[src]), 32'd0);
            exp_q.push_back(mem[src][rd[src]]);
            exp_cyc_q.push_back(cyc + 2);
            pop_log.push_back(src);
            pop_cyc_log.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        #1;
        if (src >= 0 && rd[src] < wr[src]) begin
            data_in[src*W +: W] = mem[src][rd[src]];
            rd[src]++;
            fifo_empty[src] = (rd[src] == wr[src]);
        end
    endtask

    task automatic clear_scoreboard();
        exp_q.delete();
        exp_cyc_q.delete();
        pop_log.delete();
        pop_cyc_log.delete();
        n_push = 0;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        out_almost_full = 1'b0;
        fifo_empty      = 4'hf;
        data_in         = '0;
        for (int i = 0; i < 4; i++) begin
            wr[i] = 0;
            rd[i] = 0;
        end
        clear_scoreboard();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (!(fifo_empty == 4'hf && !busy && exp_q.size() == 0) && n < 200) begin
            step();
            n++;
        end
        check(tag, 32'(n < 200), 32'd1);
        step();
        step();
    endtask

    task automatic run_until_pops(input string tag, input int target);
        int n;
        n = 0;
        while (pop_log.size() < target && n < 100) begin
            step();
            n++;
        end
        check(tag, 32'(pop_log.size()), 32'(target));
    endtask

    initial begin
        // Test 1: idle after reset with every source empty.
        do_reset();
        check("rst_pop", 32'(pop), 32'd0);
        check("rst_push", 32'(push), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 10; k++) begin
            step();
            check("idle_pop", 32'(pop), 32'd0);
            check("idle_push", 32'(push), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end

        // Test 2: lone requester, 6 words -> burst of 4, re-grant, 2 more, back to idle.
        do_reset();
        load(2, 6);
        drain("t2_drain");
        check("t2_pops", 32'(pop_log.size()), 32'd6);
        check("t2_pushes", 32'(n_push), 32'd6);
        for (int k = 0; k < pop_log.size(); k++) check("t2_src", 32'(pop_log[k]), 32'd2);
        if (pop_cyc_log.size() == 6)
            check("t2_back_to_back", 32'(pop_cyc_log[5] - pop_cyc_log[0]), 32'd5);
        check("t2_idle", 32'(busy), 32'd0);

        // Test 3: all sources loaded -> grants 0,1,2,3,0,... with 4 pops each.
        do_reset();
        for (int i = 0; i < 4; i++) load(i, 8);
        drain("t3_drain");
        check("t3_pops", 32'(pop_log.size()), 32'd32);
        check("t3_pushes", 32'(n_push), 32'd32);
        for (int k = 0; k < pop_log.size(); k++) check("t3_order", 32'(pop_log[k]), 32'((k / 4) % 4));

        // Test 4: almost_full after 2 pops, held 5 cycles; then 2 remaining pops before rotating.
        do_reset();
        load(0, 8);
        load(1, 4);
        run_until_pops("t4_first_pops", 2);
        out_almost_full = 1'b1;
        push_before     = n_push;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t4_stall_pop", 32'(pop), 32'd0);
            check("t4_stall_grant", 32'(grant_id), 32'd0);
        end
        check("t4_inflight_pushes", 32'(n_push - push_before), 32'd2);
        out_almost_full = 1'b0;
        drain("t4_drain");
        check("t4_pops", 32'(pop_log.size()), 32'd12);
        for (int k = 0; k < pop_log.size(); k++)
            check("t4_order", 32'(pop_log[k]), (k >= 4 && k < 8) ? 32'd1 : 32'd0);

        // Test 5: source 1 empties after one pop -> grant moves to source 3 on the next edge.
        do_reset();
        load(1, 1);
        load(3, 4);
        run_until_pops("t5_first_pop", 1);
        check("t5_grant_before", 32'(grant_id), 32'd1);
        step();
        check("t5_grant_after", 32'(grant_id), 32'd3);
        check("t5_busy", 32'(busy), 32'd1);
        drain("t5_drain");
        check("t5_pops", 32'(pop_log.size()), 32'd5);
        for (int k = 0; k < pop_log.size(); k++)
            check("t5_order", 32'(pop_log[k]), (k == 0) ? 32'd1 : 32'd3);

        // Test 6: reset in the cycle after a pop drops the in-flight words.
        do_reset();
        load(0, 6);
        load(1, 4);
        run_until_pops("t6_pre_pops", 5);
        check("t6_pre_push", 32'(push), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_async_pop", 32'(pop), 32'd0);
        check("t6_async_push", 32'(push), 32'd0);
        check("t6_async_data", 32'(data_out), 32'd0);
        check("t6_async_busy", 32'(busy), 32'd0);
        clear_scoreboard();
        for (int k = 0; k < 3; k++) begin
            step();
            check("t6_rst_push", 32'(push), 32'd0);
        end
        reset = 1'b0;
        drain("t6_drain");
        check("t6_pops", 32'(pop_log.size()), 32'd5);
        if (pop_log.size() > 0) check("t6_first_grant", 32'(pop_log[0]), 32'd0);
        check("t6_pushes", 32'(n_push), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
